// File: rtl/pe_ws_os.sv
// Dual-mode (weight-stationary / output-stationary) fixed-point systolic PE.
// Define PE_SATURATE_EN to clamp products and sums (with sticky O_SAT); otherwise results wrap.
module pe_ws_os #(
  parameter int D_W    = 16,
  parameter int FRAC_W = 13
) (
  input  logic           I_CLK,
  input  logic           I_ASYN_RSTN,
  input  logic [D_W-1:0] I_X,
  input  logic           I_X_VLD,
  input  logic [D_W-1:0] I_W,
  input  logic           I_W_LOAD,
  input  logic           I_W_SWAP,
  input  logic [D_W-1:0] I_D,
  input  logic           I_D_VLD,
  input  logic           I_MODE,
  input  logic           I_ACC_CLR,
  output logic [D_W-1:0] O_X,
  output logic           O_X_VLD,
  output logic [D_W-1:0] O_W,
  output logic           O_W_LOAD,
  output logic           O_W_SWAP,
  output logic [D_W-1:0] O_D,
  output logic           O_D_VLD,
  output logic           O_SAT
);

  localparam int P_W = 2 * D_W + 1;
  localparam logic [P_W-1:0] RND_C = {{(P_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
  localparam logic [D_W-1:0] MAX_C = {1'b0, {(D_W-1){1'b1}}};
  localparam logic [D_W-1:0] MIN_C = {1'b1, {(D_W-1){1'b0}}};

`ifdef PE_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic signed [D_W-1:0] w_act_r;
  logic        [D_W-1:0] w_shd_r;
  logic                  shd_vld_r;
  logic        [D_W-1:0] acc_r, acc_s;
  logic        [D_W-1:0] od_s;
  logic                  od_vld_s, sat_s;

  logic                  use_s;
  logic signed [2*D_W-1:0] mul_s;
  logic signed [P_W-1:0] prod_rnd_s, pr_wide_s;
  logic        [D_W-1:0] pr_s, ws_sum_s, acc_sum_s;
  logic        [D_W:0]   ws_wide_s, acc_wide_s;
  logic                  pr_ovf_s, ws_ovf_s, acc_ovf_s;

  // True when v is representable in D_W signed bits.
  function automatic logic fits_fn(input logic [P_W-1:0] v);
    logic [P_W-D_W:0] top_v;
    top_v   = v[P_W-1:D_W-1];
    fits_fn = (&top_v) | (~|top_v);
  endfunction

  function automatic logic [D_W-1:0] reduce_fn(input logic [P_W-1:0] v);
    if (SAT_EN && !fits_fn(v)) begin
      reduce_fn = v[P_W-1] ? MIN_C : MAX_C;
    end else begin
      reduce_fn = v[D_W-1:0];
    end
  endfunction

  function automatic logic [P_W-1:0] sext_fn(input logic [D_W:0] v);
    sext_fn = {{(P_W-D_W-1){v[D_W]}}, v};
  endfunction

  // Weight lifecycle: EMPTY until the first effective swap, then ARMED/RUN track I_X_VLD.
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (I_W_SWAP && (shd_vld_r || I_W_LOAD)) state_s = ARMED;
        else                                     state_s = EMPTY;
      end
      ARMED, RUN: begin
        if (I_X_VLD) state_s = RUN;
        else         state_s = ARMED;
      end
      default: state_s = EMPTY;
    endcase
  end

  // Rounded product and the two candidate sums.
  always_comb begin
    use_s      = I_X_VLD && (state_r != EMPTY);
    mul_s      = $signed({{D_W{I_X[D_W-1]}}, I_X}) * $signed({{D_W{w_act_r[D_W-1]}}, w_act_r});
    prod_rnd_s = $signed({mul_s[2*D_W-1], mul_s}) + $signed(RND_C);
    pr_wide_s  = prod_rnd_s >>> FRAC_W;
    if (use_s) begin
      pr_s     = reduce_fn(pr_wide_s);
      pr_ovf_s = SAT_EN & ~fits_fn(pr_wide_s);
    end else begin
      pr_s     = {D_W{1'b0}};
      pr_ovf_s = 1'b0;
    end
    ws_wide_s  = {I_D[D_W-1], I_D} + {pr_s[D_W-1], pr_s};
    acc_wide_s = {acc_r[D_W-1], acc_r} + {pr_s[D_W-1], pr_s};
    ws_sum_s   = reduce_fn(sext_fn(ws_wide_s));
    acc_sum_s  = reduce_fn(sext_fn(acc_wide_s));
    ws_ovf_s   = SAT_EN & ~fits_fn(sext_fn(ws_wide_s));
    acc_ovf_s  = SAT_EN & ~fits_fn(sext_fn(acc_wide_s));
  end

  // Next result, accumulator and saturation flag for the selected mode.
  always_comb begin
    od_s     = O_D;
    od_vld_s = 1'b0;
    acc_s    = acc_r;
    sat_s    = I_ACC_CLR ? 1'b0 : O_SAT;
    if (!I_MODE) begin
      if (use_s) begin
        od_s     = ws_sum_s;
        od_vld_s = 1'b1;
        sat_s    = sat_s | pr_ovf_s | ws_ovf_s;
      end else begin
        od_vld_s = 1'b0;
      end
    end else begin
      if (I_ACC_CLR) begin
        od_s     = acc_r;
        od_vld_s = 1'b1;
        acc_s    = pr_s;
        sat_s    = sat_s | pr_ovf_s;
      end else begin
        od_s     = I_D;
        od_vld_s = I_D_VLD;
        if (use_s) begin
          acc_s = acc_sum_s;
          sat_s = sat_s | pr_ovf_s | acc_ovf_s;
        end else begin
          acc_s = acc_r;
        end
      end
    end
  end

  // State, weight registers and accumulator.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_r   <= EMPTY;
      w_act_r   <= {D_W{1'b0}};
      w_shd_r   <= {D_W{1'b0}};
      shd_vld_r <= 1'b0;
      acc_r     <= {D_W{1'b0}};
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      // Load+swap together bypasses the shadow and leaves it untouched.
      if (I_W_LOAD && I_W_SWAP) begin
        w_act_r <= I_W;
      end else if (I_W_SWAP && shd_vld_r) begin
        w_act_r   <= w_shd_r;
        shd_vld_r <= 1'b0;
      end else if (I_W_LOAD) begin
        w_shd_r   <= I_W;
        shd_vld_r <= 1'b1;
      end
    end
  end

  // Registered outputs and neighbour forwards.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      O_X      <= {D_W{1'b0}};
      O_X_VLD  <= 1'b0;
      O_W      <= {D_W{1'b0}};
      O_W_LOAD <= 1'b0;
      O_W_SWAP <= 1'b0;
      O_D      <= {D_W{1'b0}};
      O_D_VLD  <= 1'b0;
      O_SAT    <= 1'b0;
    end else begin
      O_X      <= I_X;
      O_X_VLD  <= I_X_VLD;
      O_W      <= I_W;
      O_W_LOAD <= I_W_LOAD;
      O_W_SWAP <= I_W_SWAP;
      O_D      <= od_s;
      O_D_VLD  <= od_vld_s;
      O_SAT    <= sat_s;
    end
  end

endmodule

// File: tb/tb_pe_ws_os.sv
// Directed self-checking bench for pe_ws_os (D_W=16, FRAC_W=13); honours PE_SATURATE_EN.
module tb_pe_ws_os;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x, w, d;
  logic        x_vld, w_load, w_swap, d_vld, mode, acc_clr;
  logic [15:0] o_x, o_w, o_d;
  logic        o_x_vld, o_w_load, o_w_swap, o_d_vld, o_sat;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pe_ws_os #(.D_W(16), .FRAC_W(13)) dut (
    .I_CLK(clk), .I_ASYN_RSTN(rst_n),
    .I_X(x), .I_X_VLD(x_vld), .I_W(w), .I_W_LOAD(w_load), .I_W_SWAP(w_swap),
    .I_D(d), .I_D_VLD(d_vld), .I_MODE(mode), .I_ACC_CLR(acc_clr),
    .O_X(o_x), .O_X_VLD(o_x_vld), .O_W(o_w), .O_W_LOAD(o_w_load), .O_W_SWAP(o_w_swap),
    .O_D(o_d), .O_D_VLD(o_d_vld), .O_SAT(o_sat)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic xv, input logic [15:0] xd, input logic [15:0] dd);
    x_vld = xv;
    x     = xd;
    d     = dd;
  endtask

  initial begin
    rst_n = 1'b0;
    x = 16'h0000; w = 16'h0000; d = 16'h0000;
    x_vld = 1'b0; w_load = 1'b0; w_swap = 1'b0; d_vld = 1'b0; mode = 1'b0; acc_clr = 1'b0;
    tick(); tick();
    chk("rst_od", {16'h0000, o_d}, 32'h0);
    chk("rst_vld_sat_fwd", {27'h0, o_d_vld, o_sat, o_x_vld, o_w_load, o_w_swap}, 32'h0);
    rst_n = 1'b1;

    // Activation before any weight: no result, forwards still move
    drive(1'b1, 16'h2000, 16'h0400);
    tick();
    chk("empty_no_vld", {31'h0, o_d_vld}, 32'h0);
    chk("fwd_x", {15'h0, o_x_vld, o_x}, {15'h0, 1'b1, 16'h2000});

    // Load+swap bypass of w=0x1000
    drive(1'b0, 16'h0000, 16'h0000);
    w = 16'h1000; w_load = 1'b1; w_swap = 1'b1;
    tick();
    chk("fwd_w", {14'h0, o_w_load, o_w_swap, o_w}, {14'h0, 2'b11, 16'h1000});
    w_load = 1'b0; w_swap = 1'b0;

    drive(1'b1, 16'h2000, 16'h0400);
    tick();
    chk("ws_basic", {15'h0, o_d_vld, o_d}, {15'h0, 1'b1, 16'h1400});
    drive(1'b1, 16'h0001, 16'h0005);
    tick();
    chk("ws_round_up", {16'h0, o_d}, {16'h0, 16'h0006});
    drive(1'b1, 16'hFFFF, 16'h0005);
    tick();
    chk("ws_round_neg", {16'h0, o_d}, {16'h0, 16'h0005});
    drive(1'b0, 16'h1234, 16'h7777);
    tick();
    chk("ws_hold", {15'h0, o_d_vld, o_d}, {15'h0, 1'b0, 16'h0005});

    // Shadow load then separate swap of 0x7FFF; overflow product
    w = 16'h7FFF; w_load = 1'b1;
    tick();
    w_load = 1'b0; w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    drive(1'b1, 16'h7FFF, 16'h0000);
    tick();
`ifdef PE_SATURATE_EN
    chk("ovf_od", {16'h0, o_d}, {16'h0, 16'h7FFF});
    chk("ovf_sat", {31'h0, o_sat}, 32'h1);
`else
    chk("ovf_od", {16'h0, o_d}, {16'h0, 16'hFFF8});
    chk("ovf_sat", {31'h0, o_sat}, 32'h0);
`endif
    drive(1'b0, 16'h0000, 16'h0000);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("sat_cleared", {31'h0, o_sat}, 32'h0);

    // Swap with empty shadow is ignored: active stays 0x7FFF
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    drive(1'b1, 16'h2000, 16'h0000);
    tick();
    chk("swap_ignored", {15'h0, o_sat, o_d}, {15'h0, 1'b0, 16'h7FFF});

    // Output-stationary: w=0x2000, three beats, then drain
    drive(1'b0, 16'h0000, 16'h0000);
    mode = 1'b1; w = 16'h2000; w_load = 1'b1; w_swap = 1'b1;
    tick();
    w_load = 1'b0; w_swap = 1'b0;
    d_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h2000, 16'h0123);
      tick();
    end
    chk("os_pass", {15'h0, o_d_vld, o_d}, {15'h0, 1'b1, 16'h0123});
    drive(1'b0, 16'h0000, 16'h0000);
    d_vld = 1'b0; acc_clr = 1'b1;
    tick();
    chk("os_drain", {15'h0, o_d_vld, o_d}, {15'h0, 1'b1, 16'h6000});
    tick();
    chk("os_drain_zero", {15'h0, o_d_vld, o_d}, {15'h0, 1'b1, 16'h0000});
    acc_clr = 1'b0;
    tick();
    chk("os_idle", {31'h0, o_d_vld}, 32'h0);

    // Mode change mid-stream keeps the accumulator
    drive(1'b1, 16'h2000, 16'h0000);
    tick();
    mode = 1'b0;
    drive(1'b1, 16'h2000, 16'h0000);
    tick();
    chk("ws_between", {15'h0, o_d_vld, o_d}, {15'h0, 1'b1, 16'h2000});
    mode = 1'b1; acc_clr = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    chk("os_acc_kept", {15'h0, o_d_vld, o_d}, {15'h0, 1'b1, 16'h2000});
    acc_clr = 1'b0; mode = 1'b0;

    // Swap coincident with a beat: old weight this cycle, new one next
    w = 16'h1000; w_load = 1'b1;
    tick();
    w_load = 1'b0; w_swap = 1'b1;
    drive(1'b1, 16'h2000, 16'h0000);
    tick();
    chk("swap_old_w", {16'h0, o_d}, {16'h0, 16'h2000});
    w_swap = 1'b0;
    tick();
    chk("swap_new_w", {16'h0, o_d}, {16'h0, 16'h1000});

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("arst_od", {15'h0, o_d_vld, o_d}, 32'h0);
    chk("arst_fwd", {13'h0, o_x_vld, o_w_swap, o_w_load, o_x}, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 16'h2000, 16'h0100);
    tick();
    chk("post_rst_empty", {31'h0, o_d_vld}, 32'h0);
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    tick();
    chk("post_rst_noshadow", {31'h0, o_d_vld}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_ws_os.md
PE_WS_OS -- requirements
Module: pe_ws_os

Interface
REQ-001 Parameter D_W, default 16, data width of activation, weight and partial sum (signed two's complement).
REQ-002 Parameter FRAC_W, default 13, fraction bits of the fixed-point format; 0 < FRAC_W < D_W.
REQ-003 Port I_CLK  in  1  clock; all state changes on rising edge.
REQ-004 Port I_ASYN_RSTN  in  1  reset, asynchronous, active-low.
REQ-005 Ports I_X / I_X_VLD  in  D_W / 1  activation from left and its valid.
REQ-006 Ports I_W / I_W_LOAD / I_W_SWAP  in  D_W / 1 / 1  weight, write-shadow strobe, shadow-to-active strobe.
REQ-007 Ports I_D / I_D_VLD  in  D_W / 1  partial sum from above and its valid.
REQ-008 Ports I_MODE / I_ACC_CLR  in  1 / 1  mode (0 = weight-stationary WS, 1 = output-stationary OS); accumulator drain/clear strobe.
REQ-009 Ports O_X, O_X_VLD, O_W, O_W_LOAD, O_W_SWAP  out  D_W,1,D_W,1,1  registered forwards of I_X, I_X_VLD, I_W, I_W_LOAD, I_W_SWAP.
REQ-010 Ports O_D / O_D_VLD / O_SAT  out  D_W / 1 / 1  result, result valid, sticky saturation flag.

Function
REQ-011 Product p = I_X * active weight, signed, full 2*D_W bits; pr = (p + 2^(FRAC_W-1)) >>> FRAC_W (round half toward +inf).
REQ-012 Sum arithmetic is performed at D_W+1 bits and reduced to D_W per REQ-026/027.
REQ-013 States: EMPTY (no active weight), ARMED (active weight valid, no input), RUN (active weight valid, I_X_VLD high this cycle).
REQ-014 EMPTY->ARMED on I_W_SWAP with shadow valid or with I_W_LOAD in the same cycle; ARMED<->RUN follows I_X_VLD; no path back to EMPTY except reset.
REQ-015 I_W_LOAD: shadow <= I_W, shadow valid set; I_W_SWAP: active <= shadow, shadow valid cleared; both in one cycle: active <= I_W directly (bypass), shadow unchanged.
REQ-016 I_W_SWAP with shadow invalid and no I_W_LOAD is ignored.
REQ-017 Swap coincident with I_X_VLD: product that cycle uses old active weight; new weight effective next cycle.
REQ-018 WS mode: O_D <= I_D + pr, O_D_VLD <= I_X_VLD and state != EMPTY; latency 1 cycle; with I_X_VLD low, O_D holds and O_D_VLD <= 0.
REQ-019 OS mode: on I_X_VLD, acc <= acc + pr; O_D <= I_D and O_D_VLD <= I_D_VLD (drain chain pass-through).
REQ-020 OS mode, I_ACC_CLR: O_D <= acc, O_D_VLD <= 1, acc <= (I_X_VLD ? pr : 0); I_ACC_CLR has priority over pass-through.
REQ-021 I_X_VLD in EMPTY state: pr treated as 0, acc unchanged.
REQ-022 I_MODE is sampled each cycle; changing it mid-stream does not clear acc.
REQ-023 All O_X/O_W/strobe forwards have 1-cycle latency regardless of state or mode.

Reset
REQ-024 Asynchronous reset drives every output to 0, state to EMPTY, shadow/active weights and acc to 0, shadow valid to 0, O_SAT to 0.
REQ-025 Reset asserted mid-operation discards in-flight results; first valid O_D after release requires a new weight swap.

Configuration
REQ-026 Macro PE_SATURATE_EN defined: pr and every sum clamp to [-2^(D_W-1), 2^(D_W-1)-1]; any clamp sets O_SAT, cleared only by I_ACC_CLR or reset.
REQ-027 PE_SATURATE_EN undefined: pr and sums wrap (keep low D_W bits); O_SAT tied 0.

Verification (D_W=16, FRAC_W=13)
REQ-028 Load+swap w=0x1000, then I_X=0x2000, I_D=0x0400, WS -> next cycle O_D=0x1400, O_D_VLD=1.
REQ-029 w=0x1000, I_X=0x0001, I_D=0x0005 -> O_D=0x0006; I_X=0xFFFF, I_D=0x0005 -> O_D=0x0005.
REQ-030 w=0x7FFF, I_X=0x7FFF, I_D=0 -> PE_SATURATE_EN: O_D=0x7FFF, O_SAT=1; undefined: O_D=0xFFF8, O_SAT=0.
REQ-031 OS, w=0x2000, three beats I_X=0x2000, then I_ACC_CLR -> O_D=0x6000, O_D_VLD=1, acc=0.
REQ-032 Shadow 0x1000, active 0x2000, swap with I_X_VLD, I_X=0x2000, I_D=0 -> O_D=0x2000, next beat O_D=0x1000; I_X_VLD before any swap -> O_D_VLD stays 0; reset mid-stream -> all outputs 0 immediately.
